graphics_reg_bank: RTL
======================

Name: graphics_reg_bank

Overview:
- CPU-facing register bank sitting directly upstream of the graphics ASIC core.
- Captures writes from the CPU for paddle, ball, score and game-state values. Each write lands in a shadow register set.
- Copies the whole shadow set into the live set once per frame, at end of frame. Paddle, ball and frame/score renderers read only the live set, so objects never tear mid-frame.
- Also exports a frame pulse and a frame counter for game timing.

Parameters:
- CS_ID, 4'd2, chipselect value that selects this block.
- LAST_ADDR, 19'h4AFFF, pixel address of the final pixel in a frame (640x480-1).
- H_MAX, 16'd639, largest legal x coordinate; x writes clamp to this.
- V_MAX, 16'd479, largest legal y coordinate; y writes clamp to this.
- Z_MAX, 16'd255, largest legal ball z; z writes clamp to this.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- chipselect  in  4  bus select; write enabled when equal to CS_ID.
- databus  in  16  write data.
- data_address  in  4  register index.
- VGA_ready  in  1  VGA controller accepting pixels.
- pixel_address  in  19  current pixel address from the graphics core.
- paddle_1_x, paddle_1_y, paddle_2_x, paddle_2_y  out  16 each  live paddle positions.
- ball_x, ball_y, ball_z  out  16 each  live ball position.
- player_1_score, player_2_score  out  16 each  live scores.
- game_state  out  16  live game state.
- frame_tick  out  1  one-cycle pulse on each frame-end commit.
- frame_count  out  16  frames committed since reset; wraps 16'hFFFF -> 0.
- pending  out  1  shadow set differs from live set (write since last commit).

Behaviour:
- Reset, applied while rst==0 at a clk edge, sets shadow and live sets identically:
  - paddle_1 = (100,200); paddle_2 = (350,250).
  - ball = (320,240,0).
  - scores = 0; game_state = 0.
  - frame_tick = 0, frame_count = 0, pending = 0.
  - Internal frame-end history = 0.
- Write: occurs on a cycle when chipselect==CS_ID. The shadow register is updated at the next edge.
- Address map:
  - 0 p1x, 1 p1y, 2 p2x, 3 p2y, 4 bx, 5 by, 6 bz, 7 p1 score, 8 p2 score, 9 game_state.
  - 10 = control: databus[0]=1 requests an immediate commit; other bits are ignored.
  - 11-15 ignored: no state change and pending unchanged.
- Clamping is done on the write as an unsigned compare. x regs take min(data,H_MAX), y regs min(data,V_MAX), bz min(data,Z_MAX). Scores and game_state are stored raw.
- Every accepted write to addresses 0-9 sets pending=1 at the next edge, even if the value is unchanged.
- Chipselect held for N cycles performs N identical writes; the result is the same as one write.
- Frame-end condition: FE = VGA_ready && pixel_address==LAST_ADDR. The block registers FE and takes fe_rise = FE && !FE_prev.
- Only a rising edge commits: FE held for several cycles produces exactly one commit.
- Commit triggers: fe_rise, or a control write with bit0=1. Both in the same cycle produce one commit.
- Commit at edge:
  - live <= shadow, all 10 registers atomically.
  - frame_tick <= 1 for exactly one cycle.
  - frame_count <= frame_count+1.
  - pending <= 0.
- Commit latency: live outputs change on the edge after the trigger cycle, and frame_tick is high in the cycle after that edge.
- Write and commit in the same cycle:
  - The commit copies shadow values from before that cycle's write.
  - The write still updates the shadow.
  - pending ends at 1.
- A forced commit with pending==0 still pulses frame_tick and increments frame_count.
- Live outputs are registered and change only on commit or reset.
- Reset asserted mid-frame or mid-write wins over everything: the shadow and live sets return to their reset values.
- After reset the FE history is 0. If FE is already high in the first cycle after reset, that counts as a rising edge.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> paddle_1_x=100, paddle_2_y=250, ball_x=320, frame_count=0, pending=0.
- Write CS=2, addr0, data=200 -> paddle_1_x stays 100 and pending=1. Pulse FE for 1 cycle -> paddle_1_x=200 on the next edge, frame_tick high 1 cycle, frame_count=1, pending=0.
- Clamp: write addr1 data=1000, addr6 data=300, then commit -> paddle_1_y=479, ball_z=255. Write addr0 with CS=3 -> ignored.
- FE held high 5 cycles -> exactly one commit, frame_count+1. FE high/low/high -> two commits.
- Write addr4 data=50 in the same cycle as fe_rise -> ball_x keeps its old value and pending=1. Next FE -> ball_x=50.
- Forced commit: write addr10 data=1 with no pending -> frame_tick pulse, frame_count+1. Preload frame_count=16'hFFFF via 65535 commits -> next commit wraps to 0.

Source files
------------

// File: rtl/graphics_reg_bank.sv
`timescale 1ns/1ps
// graphics_reg_bank: CPU-written shadow registers for paddles, ball, scores and
// game state. The shadow set is copied into the live set once per frame, at
// frame end or on a forced commit, so the renderers never see a half-updated
// frame. The block also provides a frame pulse and a frame counter.
module graphics_reg_bank #(
  parameter logic [3:0]  CS_ID     = 4'd2,
  parameter logic [18:0] LAST_ADDR = 19'h4AFFF,
  parameter logic [15:0] H_MAX     = 16'd639,
  parameter logic [15:0] V_MAX     = 16'd479,
  parameter logic [15:0] Z_MAX     = 16'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  chipselect,
  input  logic [15:0] databus,
  input  logic [3:0]  data_address,
  input  logic        VGA_ready,
  input  logic [18:0] pixel_address,
  output logic [15:0] paddle_1_x,
  output logic [15:0] paddle_1_y,
  output logic [15:0] paddle_2_x,
  output logic [15:0] paddle_2_y,
  output logic [15:0] ball_x,
  output logic [15:0] ball_y,
  output logic [15:0] ball_z,
  output logic [15:0] player_1_score,
  output logic [15:0] player_2_score,
  output logic [15:0] game_state,
  output logic        frame_tick,
  output logic [15:0] frame_count,
  output logic        pending
);

  localparam int         NUM_REGS  = 10;
  localparam logic [3:0] CTRL_ADDR = 4'd10;

  logic [15:0] shadow [NUM_REGS];
  logic [15:0] live   [NUM_REGS];

  logic fe;
  logic fe_prev;
  logic fe_rise;
  logic write_en;
  logic reg_write;
  logic force_commit;
  logic commit;

  // Power-on contents shared by the shadow and live sets.
  function automatic logic [15:0] reset_value(input int idx);
    case (idx)
      0:       reset_value = 16'd100;
      1:       reset_value = 16'd200;
      2:       reset_value = 16'd350;
      3:       reset_value = 16'd250;
      4:       reset_value = 16'd320;
      5:       reset_value = 16'd240;
      default: reset_value = 16'd0;
    endcase
  endfunction

  // Coordinates are limited to the visible screen and the ball depth range;
  // scores and game state are stored as written.
  function automatic logic [15:0] clamp_value(input logic [3:0] addr,
                                              input logic [15:0] data);
    case (addr)
      4'd0, 4'd2, 4'd4: clamp_value = (data > H_MAX) ? H_MAX : data;
      4'd1, 4'd3, 4'd5: clamp_value = (data > V_MAX) ? V_MAX : data;
      4'd6:             clamp_value = (data > Z_MAX) ? Z_MAX : data;
      default:          clamp_value = data;
    endcase
  endfunction

  assign fe           = VGA_ready && (pixel_address == LAST_ADDR);
  assign fe_rise      = fe && !fe_prev;
  assign write_en     = (chipselect == CS_ID);
  assign reg_write    = write_en && (data_address < CTRL_ADDR);
  assign force_commit = write_en && (data_address == CTRL_ADDR) && databus[0];
  assign commit       = fe_rise || force_commit;

  // CPU writes land in the shadow set only, after clamping.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!rst) begin
        shadow[i] <= reset_value(i);
      end else if (reg_write && (data_address == i[3:0])) begin
        shadow[i] <= clamp_value(data_address, databus);
      end
    end
  end

  // On commit the whole live set takes the pre-write shadow values at once.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!rst) begin
        live[i] <= reset_value(i);
      end else if (commit) begin
        live[i] <= shadow[i];
      end
    end
  end

  // Frame-end edge history, frame pulse, frame counter and pending flag.
  // A write in the commit cycle leaves pending set since it is not yet live.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fe_prev     <= 1'b0;
      frame_tick  <= 1'b0;
      frame_count <= 16'd0;
      pending     <= 1'b0;
    end else begin
      fe_prev    <= fe;
      frame_tick <= commit;
      if (commit) begin
        frame_count <= frame_count + 16'd1;
      end
      if (reg_write) begin
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  assign paddle_1_x     = live[0];
  assign paddle_1_y     = live[1];
  assign paddle_2_x     = live[2];
  assign paddle_2_y     = live[3];
  assign ball_x         = live[4];
  assign ball_y         = live[5];
  assign ball_z         = live[6];
  assign player_1_score = live[7];
  assign player_2_score = live[8];
  assign game_state     = live[9];

endmodule
